// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage that issues aligned loads/stores to a handshaked data memory,
// stalls the pipeline until ack, and registers the MEM/WB payload.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] AluRes_i,
    input  logic [31:0] WrData_i,
    input  logic        MemWr_i,
    input  logic [1:0]  MemtoReg_i,
    input  logic        RegWr_i,
    input  logic [4:0]  Rf_i,
    input  logic [31:0] Ins_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [31:0] AluRes_o,
    output logic [31:0] MemData_o,
    output logic [31:0] Ins_o,
    output logic        RegWr_o,
    output logic [1:0]  MemtoReg_o,
    output logic [4:0]  Rf_o,
    output logic        valid_o,
    output logic        exc_o
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d, reg_wr_q, reg_wr_d, valid_q, valid_d, exc_q, exc_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, alu_q, alu_d, mdata_q, mdata_d, ins_q, ins_d;
    logic [1:0]  m2r_q, m2r_d;
    logic [4:0]  rf_q, rf_d;
    logic        access, aligned, take, stall;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        alu_d    = alu_q;
        mdata_d  = mdata_q;
        ins_d    = ins_q;
        reg_wr_d = reg_wr_q;
        m2r_d    = m2r_q;
        rf_d     = rf_q;
        valid_d  = valid_q;
        exc_d    = exc_q;
        stall    = 1'b0;
        take     = 1'b0;
        access   = MemWr_i || (MemtoReg_i == 2'b01);
        aligned  = (AluRes_i[1:0] == 2'b00);
        if (state_q == IDLE) begin
            if (access && aligned) begin
                stall    = 1'b1;
                state_d  = BUSY;
                req_d    = 1'b1;
                we_d     = MemWr_i;
                addr_d   = {AluRes_i[31:2], 2'b00};
                wdata_d  = WrData_i;
                valid_d  = 1'b0;
                reg_wr_d = 1'b0;
                exc_d    = 1'b0;
            end else begin
                take     = 1'b1;
                exc_d    = access;
                reg_wr_d = RegWr_i && !access;
                mdata_d  = '0;
            end
        end else if (mem_ack_i) begin
            // EX/MEM is held by the stall, so the live inputs are still this access's payload
            take     = 1'b1;
            exc_d    = 1'b0;
            reg_wr_d = RegWr_i;
            mdata_d  = we_q ? 32'd0 : mem_rdata_i;
            state_d  = IDLE;
            req_d    = 1'b0;
            we_d     = 1'b0;
            addr_d   = '0;
            wdata_d  = '0;
        end else begin
            stall    = 1'b1;
            valid_d  = 1'b0;
            reg_wr_d = 1'b0;
            exc_d    = 1'b0;
        end
        if (take) begin
            alu_d   = AluRes_i;
            ins_d   = Ins_i;
            rf_d    = Rf_i;
            m2r_d   = (MemtoReg_i == 2'b11) ? 2'b00 : MemtoReg_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            alu_q    <= '0;
            mdata_q  <= '0;
            ins_q    <= '0;
            reg_wr_q <= 1'b0;
            m2r_q    <= 2'b00;
            rf_q     <= '0;
            valid_q  <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            alu_q    <= alu_d;
            mdata_q  <= mdata_d;
            ins_q    <= ins_d;
            reg_wr_q <= reg_wr_d;
            m2r_q    <= m2r_d;
            rf_q     <= rf_d;
            valid_q  <= valid_d;
            exc_q    <= exc_d;
        end
    end

    assign stall_o     = reset && stall;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign AluRes_o    = alu_q;
    assign MemData_o   = mdata_q;
    assign Ins_o       = ins_q;
    assign RegWr_o     = reg_wr_q;
    assign MemtoReg_o  = m2r_q;
    assign Rf_o        = rf_q;
    assign valid_o     = valid_q;
    assign exc_o       = exc_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random instructions through mem_access_unit, with a
// responding memory of chosen latency and a per-instruction writeback model.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] AluRes_i = '0, WrData_i = '0, Ins_i = '0, mem_rdata_i = '0;
    logic        MemWr_i = 1'b0, RegWr_i = 1'b0, mem_ack_i = 1'b0;
    logic [1:0]  MemtoReg_i = 2'b00;
    logic [4:0]  Rf_i = '0;
    logic        mem_req_o, mem_we_o, stall_o, RegWr_o, valid_o, exc_o;
    logic [31:0] mem_addr_o, mem_wdata_o, AluRes_o, MemData_o, Ins_o;
    logic [1:0]  MemtoReg_o;
    logic [4:0]  Rf_o;
    int total = 0;
    int bad = 0;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .AluRes_i(AluRes_i), .WrData_i(WrData_i), .MemWr_i(MemWr_i), .MemtoReg_i(MemtoReg_i),
        .RegWr_i(RegWr_i), .Rf_i(Rf_i), .Ins_i(Ins_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o),
        .AluRes_o(AluRes_o), .MemData_o(MemData_o), .Ins_o(Ins_o), .RegWr_o(RegWr_o),
        .MemtoReg_o(MemtoReg_o), .Rf_o(Rf_o), .valid_o(valid_o), .exc_o(exc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Writeback model: what the MEM/WB slot must hold once an instruction retires
    task automatic chk_wb(input logic [31:0] a, input logic [31:0] ins, input logic [4:0] rf,
                          input logic [1:0] m2r, input logic rw, input logic wr, input logic [31:0] rd);
        logic acc, mis;
        acc = wr || (m2r == 2'b01);
        mis = acc && (a % 4 != 0);
        chk("alu_res", AluRes_o, a);
        chk("ins", Ins_o, ins);
        chk("rf", {27'd0, Rf_o}, {27'd0, rf});
        chk("memtoreg", {30'd0, MemtoReg_o}, (m2r == 2'b11) ? 32'd0 : {30'd0, m2r});
        chk("regwr", {31'd0, RegWr_o}, {31'd0, rw && !mis});
        chk("exc", {31'd0, exc_o}, {31'd0, mis});
        chk("memdata", MemData_o, (acc && !mis && !wr) ? rd : 32'd0);
        chk("valid", {31'd0, valid_o}, 32'd1);
        chk("req_after", {31'd0, mem_req_o}, 32'd0);
        chk("we_after", {31'd0, mem_we_o}, 32'd0);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] wd, input logic wr, input logic [1:0] m2r,
                       input logic rw, input logic [4:0] rf, input logic [31:0] ins,
                       input int lat, input logic [31:0] rd);
        @(negedge clk);
        AluRes_i = a; WrData_i = wd; MemWr_i = wr; MemtoReg_i = m2r;
        RegWr_i = rw; Rf_i = rf; Ins_i = ins;
        mem_ack_i = 1'($urandom); mem_rdata_i = $urandom;
        #1;
        if ((wr || m2r == 2'b01) && a[1:0] == 2'b00) begin
            chk("stall_issue", {31'd0, stall_o}, 32'd1);
            @(posedge clk); #1;
            chk("req", {31'd0, mem_req_o}, 32'd1);
            chk("we", {31'd0, mem_we_o}, {31'd0, wr});
            chk("addr", mem_addr_o, a);
            chk("wdata", mem_wdata_o, wd);
            chk("bubble_valid", {31'd0, valid_o}, 32'd0);
            chk("bubble_regwr", {31'd0, RegWr_o}, 32'd0);
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                mem_ack_i = (k == lat);
                mem_rdata_i = (k == lat) ? rd : $urandom;
                #1;
                chk("stall_busy", {31'd0, stall_o}, {31'd0, k != lat});
                @(posedge clk); #1;
                if (k != lat) begin
                    chk("wait_valid", {31'd0, valid_o}, 32'd0);
                    chk("hold_req", {31'd0, mem_req_o}, 32'd1);
                    chk("hold_addr", mem_addr_o, a);
                    chk("hold_wdata", mem_wdata_o, wd);
                end
            end
            mem_ack_i = 1'b0;
        end else begin
            chk("stall_none", {31'd0, stall_o}, 32'd0);
            @(posedge clk); #1;
        end
        chk_wb(a, ins, rf, m2r, rw, wr, rd);
    endtask

    initial begin
        MemWr_i = 1'b1; AluRes_i = 32'h40;
        #12;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_alu", AluRes_o, 32'd0);
        chk("rst_m2r", {30'd0, MemtoReg_o}, 32'd0);
        MemWr_i = 1'b0;
        @(negedge clk); reset = 1'b1;
        run(32'h1234, 32'h0, 1'b0, 2'b00, 1'b1, 5'd5, 32'h1111_0000, 1, 32'h0);
        run(32'h100, 32'h0, 1'b0, 2'b01, 1'b1, 5'd7, 32'h2222_0000, 3, 32'hDEADBEEF);
        run(32'h204, 32'hA5A5A5A5, 1'b1, 2'b00, 1'b0, 5'd0, 32'h3333_0000, 1, 32'h0);
        chk("store_we_1cyc", {31'd0, mem_we_o}, 32'd0);
        run(32'h102, 32'h0, 1'b0, 2'b01, 1'b1, 5'd9, 32'h4444_0000, 1, 32'h0);
        run(32'h0, 32'h0, 1'b0, 2'b10, 1'b1, 5'd31, 32'h5555_0000, 1, 32'h0);
        chk("exc_pulse", {31'd0, exc_o}, 32'd0);
        run(32'h203, 32'h77, 1'b1, 2'b01, 1'b1, 5'd3, 32'h6666_0000, 1, 32'h0);
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            run(a, $urandom, 1'($urandom_range(0, 2) == 0), 2'($urandom), 1'($urandom),
                5'($urandom), $urandom, $urandom_range(1, 4), $urandom);
        end
        @(negedge clk);
        AluRes_i = 32'h300; MemWr_i = 1'b0; MemtoReg_i = 2'b01; RegWr_i = 1'b1;
        Rf_i = 5'd12; Ins_i = 32'h7777_0000; mem_ack_i = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_req", {31'd0, mem_req_o}, 32'd1);
        @(negedge clk); reset = 1'b0; #1;
        chk("mid_rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("mid_rst_addr", mem_addr_o, 32'd0);
        chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
        chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("mid_rst_ins", Ins_o, 32'd0);
        @(negedge clk); reset = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0; #1;
        chk("post_rst_idle_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1;
        chk("stray_ack_valid", {31'd0, valid_o}, 32'd0);
        chk("reissue_req", {31'd0, mem_req_o}, 32'd1);
        @(negedge clk); mem_ack_i = 1'b1; mem_rdata_i = 32'h0C0FFEE0;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        chk_wb(32'h300, 32'h7777_0000, 5'd12, 2'b01, 1'b1, 1'b0, 32'h0C0FFEE0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
